// File: rtl/fetch_redirect_ctrl.sv
// Dual-issue fetch PC sequencer: arbitrates exception, stall, branch and jr
// redirects into one registered next-PC decision with MIPS delay-slot squashing.
module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
   parameter logic [31:0] PC_STEP  = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   input  logic        stall,
   input  logic        br_req,
   input  logic        br_slot,
   input  logic [31:0] br_target,
   input  logic        jr_req,
   input  logic        jr_slot,
   input  logic [31:0] jr_data,
   input  logic        jr_data_ok,
   output logic [31:0] pc,
   output logic        fetch_en,
   output logic        kill_hi,
   output logic        flush_id,
   output logic        addr_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_JR    = 2'd1,
      HOLD_REDIR = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        pend_slot_q, pend_slot_d;
   logic        pend_wait_q, pend_wait_d;
   logic        fetch_en_q, fetch_en_d;
   logic        kill_hi_q, kill_hi_d;
   logic        flush_id_q, flush_id_d;
   logic        addr_err_q, addr_err_d;
   logic        busy_q, busy_d;

   logic        use_jr, req_any, req_slot, req_wait;
   logic [31:0] req_tgt;
   logic        apply, app_slot;
   logic [31:0] app_tgt;

   // Same-cycle br/jr: the low-slot request wins, br wins a tie on slot.
   assign use_jr   = jr_req && (!br_req || (!jr_slot && br_slot));
   assign req_any  = br_req || jr_req;
   assign req_slot = use_jr ? jr_slot : br_slot;
   assign req_tgt  = use_jr ? jr_data : br_target;
   assign req_wait = use_jr && !jr_data_ok;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      pc_d        = pc_q;
      pend_tgt_d  = pend_tgt_q;
      pend_slot_d = pend_slot_q;
      pend_wait_d = pend_wait_q;
      fetch_en_d  = 1'b1;
      kill_hi_d   = 1'b0;
      flush_id_d  = 1'b0;
      addr_err_d  = 1'b0;
      apply       = 1'b0;
      app_slot    = 1'b0;
      app_tgt     = '0;

      if (exc_req) begin
         pc_d        = exc_pc;
         state_d     = RUN;
         pend_wait_d = 1'b0;
         flush_id_d  = 1'b1;
         addr_err_d  = |exc_pc[1:0];
      end else if (stall) begin
         fetch_en_d = 1'b0;
         if (state_q == RUN && req_any) begin
            pend_tgt_d  = req_tgt;
            pend_slot_d = req_slot;
            pend_wait_d = req_wait;
            state_d     = HOLD_REDIR;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (req_any && req_wait) begin
                  state_d     = WAIT_JR;
                  pend_slot_d = req_slot;
                  fetch_en_d  = 1'b0;
               end else if (req_any) begin
                  apply    = 1'b1;
                  app_tgt  = req_tgt;
                  app_slot = req_slot;
               end else begin
                  pc_d = pc_q + PC_STEP;
               end
            end
            WAIT_JR: begin
               if (jr_data_ok) begin
                  apply    = 1'b1;
                  app_tgt  = jr_data;
                  app_slot = pend_slot_q;
               end else begin
                  fetch_en_d = 1'b0;
               end
            end
            HOLD_REDIR: begin
               // A jr parked without its operand still needs jr_data_ok.
               if (pend_wait_q && !jr_data_ok) begin
                  state_d    = WAIT_JR;
                  fetch_en_d = 1'b0;
               end else begin
                  apply    = 1'b1;
                  app_tgt  = pend_wait_q ? jr_data : pend_tgt_q;
                  app_slot = pend_slot_q;
               end
            end
            default: state_d = RUN;
         endcase
      end

      // Slot 0: squash the fall-through pair. Slot 1: keep the pair, drop its high half.
      if (apply) begin
         pc_d        = app_tgt;
         state_d     = RUN;
         pend_wait_d = 1'b0;
         kill_hi_d   = app_slot;
         flush_id_d  = !app_slot;
         addr_err_d  = |app_tgt[1:0];
      end

      busy_d = (state_d == WAIT_JR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         pend_tgt_q  <= '0;
         pend_slot_q <= 1'b0;
         pend_wait_q <= 1'b0;
         fetch_en_q  <= 1'b0;
         kill_hi_q   <= 1'b0;
         flush_id_q  <= 1'b0;
         addr_err_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_tgt_q  <= pend_tgt_d;
         pend_slot_q <= pend_slot_d;
         pend_wait_q <= pend_wait_d;
         fetch_en_q  <= fetch_en_d;
         kill_hi_q   <= kill_hi_d;
         flush_id_q  <= flush_id_d;
         addr_err_q  <= addr_err_d;
         busy_q      <= busy_d;
      end
   end

   assign pc       = pc_q;
   assign fetch_en = fetch_en_q;
   assign kill_hi  = kill_hi_q;
   assign flush_id = flush_id_q;
   assign addr_err = addr_err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed steps push expected outputs,
// a negedge monitor pops and compares them when they fall due.
module tb_fetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        exc_req = 1'b0, stall = 1'b0;
   logic [31:0] exc_pc = '0;
   logic        br_req = 1'b0, br_slot = 1'b0;
   logic [31:0] br_target = '0;
   logic        jr_req = 1'b0, jr_slot = 1'b0, jr_data_ok = 1'b0;
   logic [31:0] jr_data = '0;
   logic [31:0] pc;
   logic        fetch_en, kill_hi, flush_id, addr_err, busy;

   fetch_redirect_ctrl dut (
      .clk(clk), .reset(reset),
      .exc_req(exc_req), .exc_pc(exc_pc), .stall(stall),
      .br_req(br_req), .br_slot(br_slot), .br_target(br_target),
      .jr_req(jr_req), .jr_slot(jr_slot), .jr_data(jr_data), .jr_data_ok(jr_data_ok),
      .pc(pc), .fetch_en(fetch_en), .kill_hi(kill_hi), .flush_id(flush_id),
      .addr_err(addr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] pc;
      logic        fe, kh, fl, ae, bz;
   } item_t;

   item_t q[$];
   item_t it;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         it = q.pop_front();
         check("pc",       it.id, pc,              it.pc);
         check("fetch_en", it.id, {31'd0, fetch_en}, {31'd0, it.fe});
         check("kill_hi",  it.id, {31'd0, kill_hi},  {31'd0, it.kh});
         check("flush_id", it.id, {31'd0, flush_id}, {31'd0, it.fl});
         check("addr_err", it.id, {31'd0, addr_err}, {31'd0, it.ae});
         check("busy",     it.id, {31'd0, busy},     {31'd0, it.bz});
      end
   end

   task automatic push(input int due, input int id, input logic [31:0] xpc,
                       input logic xfe, xkh, xfl, xae, xbz);
      item_t e;
      e.cyc = due; e.id = id; e.pc = xpc;
      e.fe = xfe; e.kh = xkh; e.fl = xfl; e.ae = xae; e.bz = xbz;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs and expect the outputs after the next edge.
   task automatic step(input int id,
                       input logic e, input logic [31:0] epc, input logic st,
                       input logic br, input logic bs, input logic [31:0] bt,
                       input logic jr, input logic js, input logic [31:0] jd, input logic jok,
                       input logic [31:0] xpc, input logic xfe, xkh, xfl, xae, xbz);
      exc_req = e; exc_pc = epc; stall = st;
      br_req = br; br_slot = bs; br_target = bt;
      jr_req = jr; jr_slot = js; jr_data = jd; jr_data_ok = jok;
      push(cyc + 1, id, xpc, xfe, xkh, xfl, xae, xbz);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int id, input logic [31:0] xpc, input logic xfl);
      step(id, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xpc, 1, 0, xfl, 0, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      push(cyc, 0, 32'hbfc0_0000, 0, 0, 0, 0, 0);

      idle(1, 32'hbfc0_0008, 0);
      idle(2, 32'hbfc0_0010, 0);
      idle(3, 32'hbfc0_0018, 0);
      step(4, 1, 32'hbfc0_0008, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0008, 1, 0, 1, 0, 0);
      idle(5, 32'hbfc0_0010, 0);
      // branch in low slot
      step(6, 0, 0, 0, 1, 0, 32'hbfc0_0100, 0, 0, 0, 0, 32'hbfc0_0100, 1, 0, 1, 0, 0);
      idle(7, 32'hbfc0_0108, 0);
      step(8, 1, 32'hbfc0_0008, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0008, 1, 0, 1, 0, 0);
      idle(9, 32'hbfc0_0010, 0);
      // branch in high slot
      step(10, 0, 0, 0, 1, 1, 32'hbfc0_0200, 0, 0, 0, 0, 32'hbfc0_0200, 1, 1, 0, 0, 0);
      idle(11, 32'hbfc0_0208, 0);
      // jr waiting for its operand three cycles
      step(12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hbfc0_0208, 0, 0, 0, 0, 1);
      step(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0208, 0, 0, 0, 0, 1);
      step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0208, 0, 0, 0, 0, 1);
      step(15, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0040, 1, 32'h8000_0040, 1, 0, 1, 0, 0);
      idle(16, 32'h8000_0048, 0);
      // exception preempts WAIT_JR; later operand ignored
      step(17, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h8000_0048, 0, 0, 0, 0, 1);
      step(18, 1, 32'hbfc0_0380, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0380, 1, 0, 1, 0, 0);
      step(19, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 1, 32'hbfc0_0388, 1, 0, 0, 0, 0);
      // branch held under stall, misaligned target
      step(20, 0, 0, 1, 1, 0, 32'hbfc0_0123, 0, 0, 0, 0, 32'hbfc0_0388, 0, 0, 0, 0, 0);
      step(21, 0, 0, 1, 1, 0, 32'hbfc0_0123, 0, 0, 0, 0, 32'hbfc0_0388, 0, 0, 0, 0, 0);
      step(22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbfc0_0123, 1, 0, 1, 1, 0);
      idle(23, 32'hbfc0_012b, 0);
      // arbitration: low-slot jr beats high-slot br
      step(24, 0, 0, 0, 1, 1, 32'hbfc0_0500, 1, 0, 32'h8000_1000, 1, 32'h8000_1000, 1, 0, 1, 0, 0);
      idle(25, 32'h8000_1008, 0);
      // arbitration: same slot, br wins
      step(26, 0, 0, 0, 1, 0, 32'h0000_0400, 1, 0, 32'h0000_0800, 1, 32'h0000_0400, 1, 0, 1, 0, 0);
      idle(27, 32'h0000_0408, 0);
      // exception ignores stall, misaligned vector, then 32-bit wrap
      step(28, 1, 32'hffff_fffa, 1, 0, 0, 0, 0, 0, 0, 0, 32'hffff_fffa, 1, 0, 1, 1, 0);
      idle(29, 32'h0000_0002, 0);
      step(30, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0002, 0, 0, 0, 0, 0);
      idle(31, 32'h0000_000a, 0);

      exc_req = 0; stall = 0; br_req = 0; jr_req = 0; jr_data_ok = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
